// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX engine and (later) the RX path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam int   UART_DIV_WIDTH = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud down-counter: reloads with div on restart or on expiry; bit_tick marks the last cycle of a bit.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops one FIFO entry per frame and shifts start/data/parity/stop onto uart_txd.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 tx_enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop_bits2,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_pop,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DIV_WIDTH-1:0] div_q, tick_div;
  logic                 par_en_q, par_q, stop2_q;
  logic                 latch, txd_n, pop_n, done_n;
  logic                 baud_restart, bit_tick;

  // Counter is held at the live divisor until START, then reloads from the latched copy.
  assign baud_restart = (state == IDLE) || (state == FETCH);
  assign tick_div     = baud_restart ? baud_div : div_q;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .restart  (baud_restart),
    .div      (tick_div),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (latch) begin
      div_q    <= baud_div;
      par_en_q <= parity_en;
      par_q    <= ^fifo_dout ^ parity_odd;
      stop2_q  <= stop_bits2;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      uart_txd <= UART_IDLE_LVL;
      fifo_pop <= 1'b0;
      tx_done  <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      uart_txd <= txd_n;
      fifo_pop <= pop_n;
      tx_done  <= done_n;
      tx_busy  <= (state_n != IDLE);
    end
  end

  // Outputs are registered, so txd_n is the level for the cycle after the coming edge.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    txd_n     = UART_IDLE_LVL;
    pop_n     = 1'b0;
    done_n    = 1'b0;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_n = FETCH;
          pop_n   = 1'b1;
        end
      end
      FETCH: begin
        latch     = 1'b1;
        shreg_n   = fifo_dout;
        bit_idx_n = '0;
        state_n   = START;
        txd_n     = UART_START_LVL;
      end
      START: begin
        txd_n = UART_START_LVL;
        if (bit_tick) begin
          state_n = DATA;
          txd_n   = shreg[0];
        end
      end
      DATA: begin
        txd_n = shreg[0];
        if (bit_tick) begin
          shreg_n = shreg >> 1;
          if (bit_idx == LAST_BIT) begin
            bit_idx_n = '0;
            if (par_en_q) begin
              state_n = PARITY;
              txd_n   = par_q;
            end else begin
              state_n = STOP;
              txd_n   = UART_IDLE_LVL;
            end
          end else begin
            bit_idx_n = bit_idx + IW'(1);
            txd_n     = shreg_n[0];
          end
        end
      end
      PARITY: begin
        txd_n = par_q;
        if (bit_tick) begin
          state_n = STOP;
          txd_n   = UART_IDLE_LVL;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop2_q && bit_idx == '0) begin
            bit_idx_n = IW'(1);
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
